// File: rtl/ir_nec_rcv.sv
// NEC infrared frame receiver.
// Measures pulse widths between IR edges and decodes 32-bit frames and repeat codes.
module ir_nec_rcv #(
  parameter int unsigned LEAD_LOW_MIN     = 400_000,
  parameter int unsigned LEAD_LOW_MAX     = 500_000,
  parameter int unsigned LEAD_HI_DATA_MIN = 200_000,
  parameter int unsigned LEAD_HI_DATA_MAX = 250_000,
  parameter int unsigned LEAD_HI_REP_MIN  = 100_000,
  parameter int unsigned LEAD_HI_REP_MAX  = 125_000,
  parameter int unsigned BIT_LOW_MIN      = 20_000,
  parameter int unsigned BIT_LOW_MAX      = 35_000,
  parameter int unsigned BIT0_HI_MIN      = 20_000,
  parameter int unsigned BIT0_HI_MAX      = 35_000,
  parameter int unsigned BIT1_HI_MIN      = 70_000,
  parameter int unsigned BIT1_HI_MAX      = 95_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       infrared_in,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       frame_valid,
  output logic       repeat_en
);

  localparam logic [19:0] LL_MIN = 20'(LEAD_LOW_MIN);
  localparam logic [19:0] LL_MAX = 20'(LEAD_LOW_MAX);
  localparam logic [19:0] HD_MIN = 20'(LEAD_HI_DATA_MIN);
  localparam logic [19:0] HD_MAX = 20'(LEAD_HI_DATA_MAX);
  localparam logic [19:0] HR_MIN = 20'(LEAD_HI_REP_MIN);
  localparam logic [19:0] HR_MAX = 20'(LEAD_HI_REP_MAX);
  localparam logic [19:0] BL_MIN = 20'(BIT_LOW_MIN);
  localparam logic [19:0] BL_MAX = 20'(BIT_LOW_MAX);
  localparam logic [19:0] B0_MIN = 20'(BIT0_HI_MIN);
  localparam logic [19:0] B0_MAX = 20'(BIT0_HI_MAX);
  localparam logic [19:0] B1_MIN = 20'(BIT1_HI_MIN);
  localparam logic [19:0] B1_MAX = 20'(BIT1_HI_MAX);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    REP_TAIL
  } state_t;

  state_t      state;
  logic [2:0]  ir_q;
  logic [19:0] cnt;
  logic [19:0] tmax;
  logic [31:0] sr;
  logic [31:0] sr_nxt;
  logic [4:0]  bit_idx;
  logic        have_frame;
  logic        fall;
  logic        rise;
  logic        timeout;
  logic        w_ll;
  logic        w_hd;
  logic        w_hr;
  logic        w_bl;
  logic        w_b0;
  logic        w_b1;
  logic        chk_ok;

  assign fall = ~ir_q[1] & ir_q[2];
  assign rise = ir_q[1] & ~ir_q[2];

  assign w_ll = (cnt >= LL_MIN) && (cnt <= LL_MAX);
  assign w_hd = (cnt >= HD_MIN) && (cnt <= HD_MAX);
  assign w_hr = (cnt >= HR_MIN) && (cnt <= HR_MAX);
  assign w_bl = (cnt >= BL_MIN) && (cnt <= BL_MAX);
  assign w_b0 = (cnt >= B0_MIN) && (cnt <= B0_MAX);
  assign w_b1 = (cnt >= B1_MIN) && (cnt <= B1_MAX);

  // Bits arrive LSB-first, so each new bit enters at the top.
  assign sr_nxt = {w_b1, sr[31:1]};
  assign chk_ok = (sr_nxt[7:0] == ~sr_nxt[15:8]) &&
                  (sr_nxt[23:16] == ~sr_nxt[31:24]);

  // Two-stage synchronizer plus one delay stage for edge detection; idles high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ir_q <= 3'b111;
    else            ir_q <= {ir_q[1:0], infrared_in};
  end

  // Width counter: restarts on each edge, saturates at all-ones.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)        cnt <= '0;
    else if (fall || rise) cnt <= '0;
    else if (cnt != '1)    cnt <= cnt + 20'd1;
  end

  // Longest legal width for the pulse currently being measured.
  always_comb begin
    tmax = '1;
    case (state)
      LEAD_LOW:  tmax = LL_MAX;
      LEAD_HIGH: tmax = HD_MAX;
      BIT_LOW:   tmax = BL_MAX;
      BIT_HIGH:  tmax = B1_MAX;
      REP_TAIL:  tmax = BL_MAX;
      default:   tmax = '1;
    endcase
  end

  assign timeout = (state != IDLE) && (cnt > tmax);

  // Frame decoder with registered outputs and one-cycle pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      bit_idx     <= '0;
      have_frame  <= 1'b0;
      addr        <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      repeat_en   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      repeat_en   <= 1'b0;
      if (timeout) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) state <= LEAD_LOW;
          end
          LEAD_LOW: begin
            if (rise) state <= w_ll ? LEAD_HIGH : IDLE;
          end
          LEAD_HIGH: begin
            if (fall) begin
              unique case (1'b1)
                w_hd: begin
                  state   <= BIT_LOW;
                  bit_idx <= '0;
                  sr      <= '0;
                end
                w_hr:    state <= REP_TAIL;
                default: state <= IDLE;
              endcase
            end
          end
          BIT_LOW: begin
            if (rise) state <= w_bl ? BIT_HIGH : IDLE;
          end
          BIT_HIGH: begin
            if (fall) begin
              if (w_b0 || w_b1) begin
                sr <= sr_nxt;
                if (bit_idx == 5'd31) begin
                  state <= IDLE;
                  if (chk_ok) begin
                    addr        <= sr_nxt[7:0];
                    data        <= sr_nxt[23:16];
                    frame_valid <= 1'b1;
                    have_frame  <= 1'b1;
                  end
                end else begin
                  state   <= BIT_LOW;
                  bit_idx <= bit_idx + 5'd1;
                end
              end else begin
                state <= IDLE;
              end
            end
          end
          REP_TAIL: begin
            if (rise) begin
              state     <= IDLE;
              repeat_en <= w_bl && have_frame;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_rcv.sv
// Bench for ir_nec_rcv with timing windows scaled down by 1000.
// Vectors drive whole frames; pulses are counted every cycle.
module tb_ir_nec_rcv;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       infrared_in = 1'b1;
  logic [7:0] addr;
  logic [7:0] data;
  logic       frame_valid;
  logic       repeat_en;

  always #10 sys_clk = ~sys_clk;

  ir_nec_rcv #(
    .LEAD_LOW_MIN(400),
    .LEAD_LOW_MAX(500),
    .LEAD_HI_DATA_MIN(200),
    .LEAD_HI_DATA_MAX(250),
    .LEAD_HI_REP_MIN(100),
    .LEAD_HI_REP_MAX(125),
    .BIT_LOW_MIN(20),
    .BIT_LOW_MAX(35),
    .BIT0_HI_MIN(20),
    .BIT0_HI_MAX(35),
    .BIT1_HI_MIN(70),
    .BIT1_HI_MAX(95)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .infrared_in(infrared_in),
    .addr(addr),
    .data(data),
    .frame_valid(frame_valid),
    .repeat_en(repeat_en)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] na;
    logic [7:0] c;
    logic [7:0] nc;
    int         fv;
    logic [7:0] ea;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [4];

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int rp_cnt = 0;
  int fv_lat = 0;
  int rp_lat = 0;
  logic [7:0] fv_addr = '0;
  logic [7:0] fv_data = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear();
    fv_cnt = 0;
    rp_cnt = 0;
    fv_lat = 0;
    rp_lat = 0;
  endtask

  // Holds the line for n cycles, logging any output pulse and its cycle index.
  task automatic hold(logic v, int n);
    infrared_in = v;
    for (int i = 1; i <= n; i++) begin
      @(posedge sys_clk);
      #1;
      if (frame_valid) begin
        fv_cnt++;
        fv_lat = i;
        fv_addr = addr;
        fv_data = data;
      end
      if (repeat_en) begin
        rp_cnt++;
        rp_lat = i;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic send_bits(logic [7:0] a, logic [7:0] na,
                           logic [7:0] c, logic [7:0] nc,
                           int nbits, int lead_lo);
    logic [31:0] w;
    w = {nc, c, na, a};
    hold(1'b0, lead_lo);
    hold(1'b1, 225);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 28);
      hold(1'b1, w[i] ? 84 : 28);
    end
    if (nbits == 32) hold(1'b0, 28);
  endtask

  task automatic send_frame(logic [7:0] a, logic [7:0] na,
                            logic [7:0] c, logic [7:0] nc);
    send_bits(a, na, c, nc, 32, 450);
    hold(1'b1, 200);
  endtask

  task automatic send_rep();
    hold(1'b0, 450);
    hold(1'b1, 112);
    hold(1'b0, 28);
    hold(1'b1, 200);
  endtask

  initial begin
    tbl[0] = '{8'h10, 8'hEF, 8'h18, 8'hE6, 0, 8'h00, 8'h00};
    tbl[1] = '{8'h10, 8'hEF, 8'h18, 8'hE7, 1, 8'h10, 8'h18};
    tbl[2] = '{8'hA5, 8'h5B, 8'h33, 8'hCC, 0, 8'h10, 8'h18};
    tbl[3] = '{8'h00, 8'hFF, 8'h45, 8'hBA, 1, 8'h00, 8'h45};

    @(negedge sys_clk);
    hold(1'b1, 5);
    check("rst_addr", addr, 8'h00);
    check("rst_data", data, 8'h00);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_rp", repeat_en, 1'b0);
    sys_rst_n = 1'b1;
    hold(1'b1, 20);

    clear();
    send_rep();
    check("rep_noframe_cnt", rp_cnt, 0);
    check("rep_noframe_data", data, 8'h00);
    check("rep_noframe_addr", addr, 8'h00);

    clear();
    send_bits(8'h00, 8'hFF, 8'h99, 8'h66, 32, 350);
    hold(1'b1, 200);
    check("short_lead_fv", fv_cnt, 0);
    check("short_lead_data", data, 8'h00);

    for (int k = 0; k < 4; k++) begin
      clear();
      send_frame(tbl[k].a, tbl[k].na, tbl[k].c, tbl[k].nc);
      check($sformatf("vec%0d_fv", k), fv_cnt, tbl[k].fv);
      check($sformatf("vec%0d_addr", k), addr, tbl[k].ea);
      check($sformatf("vec%0d_data", k), data, tbl[k].ed);
      check($sformatf("vec%0d_rp", k), rp_cnt, 0);
      if (tbl[k].fv == 1) begin
        check($sformatf("vec%0d_lat", k), fv_lat, 3);
        check($sformatf("vec%0d_fv_addr", k), fv_addr, tbl[k].ea);
        check($sformatf("vec%0d_fv_data", k), fv_data, tbl[k].ed);
      end
    end

    clear();
    hold(1'b1, 2000);
    send_rep();
    hold(1'b1, 5500);
    send_rep();
    check("rep_cnt", rp_cnt, 2);
    check("rep_lat", rp_lat, 3);
    check("rep_fv", fv_cnt, 0);
    check("rep_data", data, 8'h45);

    clear();
    send_bits(8'h00, 8'hFF, 8'h0C, 8'hF3, 10, 450);
    hold(1'b0, 28);
    hold(1'b1, 250);
    check("partial_fv", fv_cnt, 0);
    send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3);
    check("after_to_fv", fv_cnt, 1);
    check("after_to_data", data, 8'h0C);

    clear();
    send_bits(8'h00, 8'hFF, 8'h33, 8'hCC, 32, 501);
    hold(1'b1, 200);
    check("lead_max_fv", fv_cnt, 1);
    check("lead_max_data", data, 8'h33);
    clear();
    send_bits(8'h00, 8'hFF, 8'h77, 8'h88, 32, 502);
    hold(1'b1, 200);
    check("lead_over_fv", fv_cnt, 0);
    check("lead_over_data", data, 8'h33);

    clear();
    send_bits(8'h00, 8'hFF, 8'h5A, 8'hA5, 20, 450);
    hold(1'b0, 10);
    sys_rst_n = 1'b0;
    hold(1'b0, 5);
    check("midrst_addr", addr, 8'h00);
    check("midrst_data", data, 8'h00);
    hold(1'b1, 100);
    sys_rst_n = 1'b1;
    hold(1'b1, 100);
    check("midrst_nopulse", fv_cnt + rp_cnt, 0);
    send_frame(8'h00, 8'hFF, 8'h5A, 8'hA5);
    check("postrst_fv", fv_cnt, 1);
    check("postrst_data", data, 8'h5A);
    check("postrst_addr", addr, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
